draw_score: RTL and testbench
=============================

DRAW_SCORE -- requirements
Module: draw_score

Interface
REQ-001 SHALL have parameter XPOS_PL1, default 256: left x of player-1 score field (pixels).
REQ-002 SHALL have parameter XPOS_PL2, default 752: left x of player-2 score field.
REQ-003 SHALL have parameter YPOS, default 40: top y of both score fields.
REQ-004 SHALL have parameter COLOR, default 12'hF_F_0: RGB of glyph pixels.
REQ-005 SHALL have one clock and a synchronous active-high reset: pclk and rst.
REQ-006 pclk  input  1  65 MHz pixel clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 vga_in  input  VGA_BUS_SIZE  bus from draw_ball (hcount, vcount, sync, blank, rgb).
REQ-009 vga_out  output  VGA_BUS_SIZE  bus with score overlay, to top-level pins.
REQ-010 pl1_score / pl2_score  input  5 each  binary scores 0..31 from uart_demux.
REQ-011 char_addr  output  11  font ROM address {char_code[6:0], glyph_line[3:0]}.
REQ-012 char_line  input  8  font ROM row; bit 7 = leftmost pixel; valid one pclk after char_addr.

Function
REQ-013 Each field: two 8x16 digit glyphs (tens at X, units at X+8); field = x in [X, X+15], y in [YPOS, YPOS+15].
REQ-014 Latency vga_in->vga_out: exactly 2 pclk for every bus field (hcount, vcount, hsync, vsync, hblnk, vblnk, rgb).
REQ-015 Stage 1: from hcount/vcount select field, digit, glyph_line = vcount-YPOS; drive char_addr = {7'h30+digit, line}; outside fields drive char_addr = 0.
REQ-016 Stage 2: pixel = char_line[7 - x_offset[2:0]] with stage-1-registered offset; if in-field, pixel set, and neither blank active -> rgb_out = COLOR, else delayed rgb_in.
REQ-017 Leading-zero suppression: tens digit 0 renders nothing (rgb passes through).
REQ-018 Scores snapshotted only on the pclk where vblnk_in goes 0->1; inputs ignored elsewhere (no mid-frame tearing).
REQ-019 Binary->BCD by sequential shift-add-3 FSM: IDLE -> CONVERT (5 cycles, one per bit, both players in parallel) -> LOAD (1 cycle) -> IDLE.
REQ-020 LOAD writes displayed tens/units registers atomically for both players; conversion done within 7 pclk of vblank start.
REQ-021 vblnk rising while FSM not IDLE: restart CONVERT with new snapshot.
REQ-022 Score 0 renders "0" only; 31 renders "31"; 5-bit width makes >31 impossible.
REQ-023 Fields overlapping (misparameterised): player-1 field has priority.

Reset
REQ-024 On rst: vga_out all-zero, char_addr 0, pipeline registers 0, FSM IDLE, displayed digits 0/0 for both players.
REQ-025 rst mid-CONVERT abandons conversion; first post-reset vblank rising edge starts fresh.

Configuration
REQ-026 Macro DRAW_SCORE_BOX_EN defined: in-field non-glyph pixels (not blanked) drive 12'h0_0_0 (black backing box, both digit cells even if tens suppressed).
REQ-027 Macro undefined: non-glyph pixels pass delayed rgb_in; box logic absent.

Structure
REQ-028 Bus width, field bit slices, and glyph size constants (8, 16) SHALL come from _vga_macros.vh; ASCII digit base 7'h30 in same header.
REQ-029 One sub-module bin2bcd_seq (5-bit in, start, done, tens/units out) SHALL hold the FSM, instantiated twice.
REQ-030 Font ROM is external (font_rom, 1-cycle sync read) in top level.

Verification
REQ-031 pl1=7, pl2=12, one frame -> pl1 field draws only "7" glyph at x 264..271; pl2 draws "1","2" at 752..767, y 40..55.
REQ-032 Change pl1 from 3 to 9 at mid-frame vcount=300 -> current frame still shows "3", next frame "9".
REQ-033 Any hcount/vcount step on vga_in -> identical values on vga_out exactly 2 pclk later; rgb unchanged outside fields.
REQ-034 Assert rst 3 cycles into CONVERT -> vga_out 0, digits 0; next vblank rising -> correct digits after 7 pclk.
REQ-035 pl1=31 with/without DRAW_SCORE_BOX_EN -> box build: field background 0x000; plain build: background equals draw_ball rgb.
REQ-036 Blanked pixels inside field coordinates -> rgb_out equals delayed rgb_in, never COLOR.

Source files
------------

// File: rtl/draw_score_pkg.sv
// ============================================================================
// Module      : draw_score_pkg
// Description : Shared VGA bus layout, glyph geometry, ASCII digit base and
//               BCD-conversion types for the score overlay.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package draw_score_pkg;

    // VGA bus geometry (bus width and field slices come from this layout)
    localparam int c_hcount_w     = 11;
    localparam int c_vcount_w     = 11;
    localparam int c_rgb_w        = 12;
    localparam int c_vga_bus_size = c_hcount_w + c_vcount_w + 4 + c_rgb_w;

    // Glyph geometry: each digit is an 8x16 cell, a field is two cells wide
    localparam int c_glyph_w = 8;
    localparam int c_glyph_h = 16;
    localparam int c_field_w = 2 * c_glyph_w;

    // ASCII code of '0'; digit d lives at c_ascii_zero + d in the font ROM
    localparam logic [6:0] c_ascii_zero = 7'h30;

    // Score / BCD widths: {tens, units, binary} double-dabble register
    localparam int c_bin_w = 5;
    localparam int c_bcd_w = 4;
    localparam int c_dd_w  = 2 * c_bcd_w + c_bin_w;

    // Bus layout, MSB first: hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    typedef struct packed {
        logic [c_hcount_w-1:0] hcount;
        logic [c_vcount_w-1:0] vcount;
        logic                  hsync;
        logic                  vsync;
        logic                  hblnk;
        logic                  vblnk;
        logic [c_rgb_w-1:0]    rgb;
    } vga_bus_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_LOAD    = 2'd2
    } bcd_state_t;

    // One shift-add-3 step: correct each BCD nibble >= 5, then shift left
    // so the next binary bit enters the units nibble.
    function automatic logic [c_dd_w-1:0] dd_step(input logic [c_dd_w-1:0] v);
        logic [c_bcd_w-1:0] t;
        logic [c_bcd_w-1:0] u;
        t = v[c_dd_w-1 -: c_bcd_w];
        u = v[c_bin_w + c_bcd_w - 1 -: c_bcd_w];
        if (t >= 4'd5) t = t + 4'd3;
        if (u >= 4'd5) u = u + 4'd3;
        return {t, u, v[c_bin_w-1:0]} << 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential 5-bit binary to two-digit BCD converter using the
//               shift-add-3 algorithm, one bit per clock.
//               IDLE -> CONVERT (5 cycles) -> LOAD (1 cycle, done high) -> IDLE.
//               A start pulse in any state restarts with the new value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
    import draw_score_pkg::*;
(
    input  logic                 pclk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [c_bin_w-1:0]   bin,
    output logic                 done,
    output logic [c_bcd_w-1:0]   tens,
    output logic [c_bcd_w-1:0]   units
);

    bcd_state_t          r_state;
    bcd_state_t          w_state_next;
    logic [c_dd_w-1:0]   r_dd;
    logic [c_dd_w-1:0]   w_dd_next;
    logic [2:0]          r_cnt;
    logic [2:0]          w_cnt_next;

    // State, shift register and bit counter
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_dd    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_dd    <= w_dd_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic; a start pulse overrides whatever is in flight
    always_comb begin
        w_state_next = r_state;
        w_dd_next    = r_dd;
        w_cnt_next   = r_cnt;
        done         = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_state_next = S_IDLE;
            end
            S_CONVERT: begin
                w_dd_next  = dd_step(r_dd);
                w_cnt_next = r_cnt + 3'd1;
                if (r_cnt == 3'(c_bin_w - 1)) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                // A restart in the same cycle drops the stale result
                done         = ~start;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (start) begin
            w_state_next = S_CONVERT;
            w_dd_next    = {{(2*c_bcd_w){1'b0}}, bin};
            w_cnt_next   = '0;
        end
    end

    assign tens  = r_dd[c_dd_w-1 -: c_bcd_w];
    assign units = r_dd[c_bin_w + c_bcd_w - 1 -: c_bcd_w];

endmodule

`default_nettype wire

// File: rtl/draw_score.sv
// ============================================================================
// Module      : draw_score
// Description : Overlays two-digit scores for two players on the VGA stream.
//               Two-stage pipeline: stage 1 decodes the field/digit and drives
//               the external font ROM address, stage 2 picks the glyph pixel
//               from the ROM row. Scores are captured at vblank start and
//               converted to BCD by two sequential converters.
// Options     : DRAW_SCORE_BOX_EN - in-field non-glyph pixels are painted black
//               (backing box behind both digit cells).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module draw_score
    import draw_score_pkg::*;
#(
    parameter int          XPOS_PL1 = 256,
    parameter int          XPOS_PL2 = 752,
    parameter int          YPOS     = 40,
    parameter logic [11:0] COLOR    = 12'hF_F_0
) (
    input  logic                      pclk,
    input  logic                      rst,
    input  logic [c_vga_bus_size-1:0] vga_in,
    output logic [c_vga_bus_size-1:0] vga_out,
    input  logic [c_bin_w-1:0]        pl1_score,
    input  logic [c_bin_w-1:0]        pl2_score,
    output logic [10:0]               char_addr,
    input  logic [7:0]                char_line
);

`ifdef DRAW_SCORE_BOX_EN
    localparam logic [c_rgb_w-1:0] c_box_rgb = 12'h0_0_0;
`endif

    vga_bus_t w_in;
    assign w_in = vga_in;

    // ------------------------------------------------------------------
    // Score capture and BCD conversion
    // ------------------------------------------------------------------
    logic               r_vblnk_prev;
    logic               w_vblnk_rise;
    logic               w_done_pl1;
    logic               w_done_pl2;
    logic [c_bcd_w-1:0] w_tens_pl1;
    logic [c_bcd_w-1:0] w_units_pl1;
    logic [c_bcd_w-1:0] w_tens_pl2;
    logic [c_bcd_w-1:0] w_units_pl2;
    logic [c_bcd_w-1:0] r_pl1_tens;
    logic [c_bcd_w-1:0] r_pl1_units;
    logic [c_bcd_w-1:0] r_pl2_tens;
    logic [c_bcd_w-1:0] r_pl2_units;

    // Remember previous vblank level to find the start of vertical blanking
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_vblnk_prev <= 1'b0;
        end else begin
            r_vblnk_prev <= w_in.vblnk;
        end
    end

    // Scores are sampled only here, so a mid-frame change cannot tear
    assign w_vblnk_rise = w_in.vblnk & ~r_vblnk_prev;

    bin2bcd_seq u_bcd_pl1 (
        .pclk  (pclk),
        .rst   (rst),
        .start (w_vblnk_rise),
        .bin   (pl1_score),
        .done  (w_done_pl1),
        .tens  (w_tens_pl1),
        .units (w_units_pl1)
    );

    bin2bcd_seq u_bcd_pl2 (
        .pclk  (pclk),
        .rst   (rst),
        .start (w_vblnk_rise),
        .bin   (pl2_score),
        .done  (w_done_pl2),
        .tens  (w_tens_pl2),
        .units (w_units_pl2)
    );

    // Both converters run in lockstep; update all displayed digits together
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_pl1_tens  <= '0;
            r_pl1_units <= '0;
            r_pl2_tens  <= '0;
            r_pl2_units <= '0;
        end else if (w_done_pl1 && w_done_pl2) begin
            r_pl1_tens  <= w_tens_pl1;
            r_pl1_units <= w_units_pl1;
            r_pl2_tens  <= w_tens_pl2;
            r_pl2_units <= w_units_pl2;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: field / digit decode and font ROM address
    // ------------------------------------------------------------------
    logic [c_hcount_w-1:0] w_dx_pl1;
    logic [c_hcount_w-1:0] w_dx_pl2;
    logic [c_vcount_w-1:0] w_dy;
    logic                  w_in_rows;
    logic                  w_hit;
    logic [c_hcount_w-1:0] w_dx;
    logic [c_bcd_w-1:0]    w_tens;
    logic [c_bcd_w-1:0]    w_units;
    logic [c_bcd_w-1:0]    w_digit;
    logic                  w_suppress;

    // Unsigned wrap makes "coordinate - origin < size" a one-sided range test
    assign w_dx_pl1  = w_in.hcount - c_hcount_w'(XPOS_PL1);
    assign w_dx_pl2  = w_in.hcount - c_hcount_w'(XPOS_PL2);
    assign w_dy      = w_in.vcount - c_vcount_w'(YPOS);
    assign w_in_rows = (w_dy < c_vcount_w'(c_glyph_h));

    // Field select with player 1 winning any overlap, then digit/address
    always_comb begin
        w_hit   = 1'b0;
        w_dx    = '0;
        w_tens  = '0;
        w_units = '0;
        if (w_in_rows && (w_dx_pl1 < c_hcount_w'(c_field_w))) begin
            w_hit   = 1'b1;
            w_dx    = w_dx_pl1;
            w_tens  = r_pl1_tens;
            w_units = r_pl1_units;
        end else if (w_in_rows && (w_dx_pl2 < c_hcount_w'(c_field_w))) begin
            w_hit   = 1'b1;
            w_dx    = w_dx_pl2;
            w_tens  = r_pl2_tens;
            w_units = r_pl2_units;
        end

        // Offset bit 3 separates the tens cell (0..7) from the units cell
        w_digit    = w_dx[3] ? w_units : w_tens;
        w_suppress = w_hit && !w_dx[3] && (w_tens == '0);

        char_addr = '0;
        if (w_hit && !rst) begin
            char_addr = {c_ascii_zero + {3'b000, w_digit}, w_dy[3:0]};
        end
    end

    vga_bus_t   r_s1_bus;
    logic       r_s1_hit;
    logic [2:0] r_s1_xoff;
    logic       r_s1_suppress;

    // Stage-1 register: delayed bus plus the decode needed once the ROM answers
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_s1_bus      <= '0;
            r_s1_hit      <= 1'b0;
            r_s1_xoff     <= '0;
            r_s1_suppress <= 1'b0;
        end else begin
            r_s1_bus      <= w_in;
            r_s1_hit      <= w_hit;
            r_s1_xoff     <= w_dx[2:0];
            r_s1_suppress <= w_suppress;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: glyph pixel select and colour mux
    // ------------------------------------------------------------------
    logic     w_pixel;
    logic     w_blank;
    vga_bus_t w_out;
    vga_bus_t r_out;

    // ROM row bit 7 is the leftmost pixel of the cell
    assign w_pixel = char_line[3'd7 - r_s1_xoff];
    assign w_blank = r_s1_bus.hblnk | r_s1_bus.vblnk;

    // Paint glyph pixels; blanked pixels always keep the incoming colour
    always_comb begin
        w_out = r_s1_bus;
`ifdef DRAW_SCORE_BOX_EN
        if (r_s1_hit && !w_blank) begin
            w_out.rgb = (w_pixel && !r_s1_suppress) ? COLOR : c_box_rgb;
        end
`else
        if (r_s1_hit && !w_blank && w_pixel && !r_s1_suppress) begin
            w_out.rgb = COLOR;
        end
`endif
    end

    // Output register: completes the two-clock bus latency
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_out <= '0;
        end else begin
            r_out <= w_out;
        end
    end

    assign vga_out = r_out;

endmodule

`default_nettype wire

// File: tb/tb_draw_score.sv
// ============================================================================
// Module      : tb_draw_score
// Description : Directed self-checking bench for draw_score. Drives synthetic
//               VGA coordinates, models the external font ROM, and compares
//               the overlaid bus against hand-derived expectations.
// Options     : DRAW_SCORE_BOX_EN - expectations follow the backing-box build
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_draw_score;

    localparam logic [11:0] COL = 12'hFF0;
`ifdef DRAW_SCORE_BOX_EN
    localparam bit BOX = 1'b1;
`else
    localparam bit BOX = 1'b0;
`endif

    logic        pclk;
    logic        rst;
    logic [37:0] vga_in;
    logic [37:0] vga_out;
    logic [4:0]  pl1_score;
    logic [4:0]  pl2_score;
    logic [10:0] char_addr;
    logic [7:0]  char_line;

    int n_tests = 0;
    int n_fail  = 0;

    draw_score dut (
        .pclk      (pclk),
        .rst       (rst),
        .vga_in    (vga_in),
        .vga_out   (vga_out),
        .pl1_score (pl1_score),
        .pl2_score (pl2_score),
        .char_addr (char_addr),
        .char_line (char_line)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Font ROM model: 1-cycle read; digit rows are {digit, line} ^ 8'h3C
    always @(posedge pclk) begin
        if (char_addr[10:4] >= 7'h30 && char_addr[10:4] <= 7'h39)
            char_line <= char_addr[7:0] ^ 8'h3C;
        else
            char_line <= 8'h00;
    end

    function automatic logic [37:0] mkbus(input logic [10:0] h, input logic [10:0] v,
                                          input logic hs, input logic vs,
                                          input logic hb, input logic vb,
                                          input logic [11:0] rgb);
        return {h, v, hs, vs, hb, vb, rgb};
    endfunction

    // Expected colour of an unblanked in-field pixel at cell offset k, line l
    function automatic logic [11:0] exp_rgb(input int tens, input int units,
                                            input int k, input int l,
                                            input logic [11:0] bg);
        int d;
        logic [7:0] row;
        logic lit;
        logic [3:0] dn;
        logic [3:0] ln;
        d   = (k < 8) ? tens : units;
        dn  = 4'(d);
        ln  = 4'(l);
        row = {dn, ln} ^ 8'h3C;
        lit = row[3'(7 - (k % 8))];
        if (k < 8 && tens == 0) lit = 1'b0;
        if (lit) return COL;
        return BOX ? 12'h000 : bg;
    endfunction

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    // Present a new score pair at vblank start, then scramble the inputs
    task automatic load_scores(input logic [4:0] a, input logic [4:0] b);
        vga_in = mkbus(11'd0, 11'd600, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        tick;
        pl1_score = a;
        pl2_score = b;
        vga_in = mkbus(11'd0, 11'd600, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        tick;
        pl1_score = ~a;
        pl2_score = ~b;
        repeat (7) tick;
        vga_in = mkbus(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        pl1_score = 5'd7;
        pl2_score = 5'd12;
        vga_in = mkbus(11'd264, 11'd45, 1'b1, 1'b1, 1'b0, 1'b0, 12'h5A5);
        repeat (3) tick;
        n_tests++;
        if (vga_out !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_vga_out: got %h expected 0", vga_out);
        end
        n_tests++;
        if (char_addr !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_char_addr: got %h expected 0", char_addr);
        end
        rst = 1'b0;
        vga_in = mkbus(11'd266, 11'd42, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321);
        #1;
        n_tests++;
        if (char_addr !== 11'h302) begin
            n_fail++;
            $display("FAIL reset_digit_addr: got %h expected 302", char_addr);
        end
        tick;
        tick;
        n_tests++;
        if (vga_out[11:0] !== exp_rgb(0, 0, 10, 2, 12'h321)) begin
            n_fail++;
            $display("FAIL reset_digit_pixel: got %h expected %h", vga_out[11:0], exp_rgb(0, 0, 10, 2, 12'h321));
        end
    endtask

    task automatic test_latency;
        logic [37:0] vec [12];
        for (int i = 0; i < 12; i++) begin
            vec[i] = mkbus(11'(100 + 7 * i), 11'(500 + i), i[0], i[1], i[2], i[3],
                           12'(i * 12'h135 + 12'h0F0));
        end
        for (int i = 0; i <= 12; i++) begin
            if (i < 12) vga_in = vec[i];
            else vga_in = mkbus(11'd0, 11'd600, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
            tick;
            if (i >= 1) begin
                n_tests++;
                if (vga_out !== vec[i - 1]) begin
                    n_fail++;
                    $display("FAIL latency_%0d: got %h expected %h", i - 1, vga_out, vec[i - 1]);
                end
            end
        end
        repeat (8) tick;
    endtask

    task automatic test_digits;
        logic [11:0] expv [16];
        logic [10:0] bx [4];
        logic [10:0] by [4];
        load_scores(5'd7, 5'd12);
        // Player 1, line 5: tens suppressed, units '7' at x 264..271
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                vga_in = mkbus(11'(256 + i), 11'd45, 1'b0, 1'b0, 1'b0, 1'b0, 12'(12'h0A0 + i));
                expv[i] = exp_rgb(0, 7, i, 5, 12'(12'h0A0 + i));
            end else begin
                vga_in = mkbus(11'd0, 11'd600, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
            end
            tick;
            if (i >= 1) begin
                n_tests++;
                if (vga_out[11:0] !== expv[i - 1]) begin
                    n_fail++;
                    $display("FAIL pl1_7_x%0d: got %h expected %h", 255 + i, vga_out[11:0], expv[i - 1]);
                end
            end
        end
        // Player 2, line 10: '1' '2' at x 752..767
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                vga_in = mkbus(11'(752 + i), 11'd50, 1'b0, 1'b0, 1'b0, 1'b0, 12'(12'h30C + i));
                expv[i] = exp_rgb(1, 2, i, 10, 12'(12'h30C + i));
            end else begin
                vga_in = mkbus(11'd0, 11'd600, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
            end
            tick;
            if (i >= 1) begin
                n_tests++;
                if (vga_out[11:0] !== expv[i - 1]) begin
                    n_fail++;
                    $display("FAIL pl2_12_x%0d: got %h expected %h", 751 + i, vga_out[11:0], expv[i - 1]);
                end
            end
        end
        // ROM addresses inside the fields
        vga_in = mkbus(11'd752, 11'd55, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        #1;
        n_tests++;
        if (char_addr !== 11'h31F) begin
            n_fail++;
            $display("FAIL addr_pl2_tens: got %h expected 31F", char_addr);
        end
        vga_in = mkbus(11'd258, 11'd45, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        #1;
        n_tests++;
        if (char_addr !== 11'h305) begin
            n_fail++;
            $display("FAIL addr_pl1_tens: got %h expected 305", char_addr);
        end
        // Just outside the field edges: address 0 and colour untouched
        bx[0] = 11'd255; by[0] = 11'd45;
        bx[1] = 11'd272; by[1] = 11'd45;
        bx[2] = 11'd264; by[2] = 11'd39;
        bx[3] = 11'd769; by[3] = 11'd56;
        for (int i = 0; i < 4; i++) begin
            vga_in = mkbus(bx[i], by[i], 1'b0, 1'b0, 1'b0, 1'b0, 12'h777);
            #1;
            n_tests++;
            if (char_addr !== 11'd0) begin
                n_fail++;
                $display("FAIL edge_addr_%0d: got %h expected 0", i, char_addr);
            end
            tick;
            tick;
            n_tests++;
            if (vga_out[11:0] !== 12'h777) begin
                n_fail++;
                $display("FAIL edge_rgb_%0d: got %h expected 777", i, vga_out[11:0]);
            end
        end
    endtask

    task automatic test_blank;
        // Offset 9, line 5 of '7' is a lit pixel
        pl1_score = 5'd7;
        pl2_score = 5'd12;
        vga_in = mkbus(11'd265, 11'd45, 1'b0, 1'b0, 1'b0, 1'b0, 12'h246);
        tick;
        tick;
        n_tests++;
        if (vga_out[11:0] !== COL) begin
            n_fail++;
            $display("FAIL blank_ref_lit: got %h expected %h", vga_out[11:0], COL);
        end
        vga_in = mkbus(11'd265, 11'd45, 1'b0, 1'b0, 1'b1, 1'b0, 12'h246);
        tick;
        tick;
        n_tests++;
        if (vga_out[11:0] !== 12'h246) begin
            n_fail++;
            $display("FAIL blank_hblnk: got %h expected 246", vga_out[11:0]);
        end
        vga_in = mkbus(11'd265, 11'd45, 1'b0, 1'b0, 1'b0, 1'b1, 12'h468);
        tick;
        tick;
        n_tests++;
        if (vga_out[11:0] !== 12'h468) begin
            n_fail++;
            $display("FAIL blank_vblnk: got %h expected 468", vga_out[11:0]);
        end
        vga_in = mkbus(11'd0, 11'd600, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        repeat (8) tick;
    endtask

    task automatic test_midframe;
        logic [11:0] expv [16];
        load_scores(5'd3, 5'd12);
        pl1_score = 5'd9;
        vga_in = mkbus(11'd100, 11'd300, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        repeat (3) tick;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                vga_in = mkbus(11'(256 + i), 11'd43, 1'b0, 1'b0, 1'b0, 1'b0, 12'h555);
                expv[i] = exp_rgb(0, 3, i, 3, 12'h555);
            end else begin
                vga_in = mkbus(11'd0, 11'd600, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
            end
            tick;
            if (i >= 1 && i >= 9) begin
                n_tests++;
                if (vga_out[11:0] !== expv[i - 1]) begin
                    n_fail++;
                    $display("FAIL midframe_still3_x%0d: got %h expected %h", 255 + i, vga_out[11:0], expv[i - 1]);
                end
            end
        end
        load_scores(5'd9, 5'd12);
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                vga_in = mkbus(11'(256 + i), 11'd43, 1'b0, 1'b0, 1'b0, 1'b0, 12'h555);
                expv[i] = exp_rgb(0, 9, i, 3, 12'h555);
            end else begin
                vga_in = mkbus(11'd0, 11'd600, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
            end
            tick;
            if (i >= 9) begin
                n_tests++;
                if (vga_out[11:0] !== expv[i - 1]) begin
                    n_fail++;
                    $display("FAIL nextframe_9_x%0d: got %h expected %h", 255 + i, vga_out[11:0], expv[i - 1]);
                end
            end
        end
    endtask

    task automatic test_extremes;
        logic [11:0] expv [16];
        load_scores(5'd0, 5'd31);
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                vga_in = mkbus(11'(256 + i), 11'd47, 1'b0, 1'b0, 1'b0, 1'b0, 12'h1E1);
                expv[i] = exp_rgb(0, 0, i, 7, 12'h1E1);
            end else begin
                vga_in = mkbus(11'd0, 11'd600, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
            end
            tick;
            if (i >= 1) begin
                n_tests++;
                if (vga_out[11:0] !== expv[i - 1]) begin
                    n_fail++;
                    $display("FAIL score0_x%0d: got %h expected %h", 255 + i, vga_out[11:0], expv[i - 1]);
                end
            end
        end
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                vga_in = mkbus(11'(752 + i), 11'd47, 1'b0, 1'b0, 1'b0, 1'b0, 12'h1E1);
                expv[i] = exp_rgb(3, 1, i, 7, 12'h1E1);
            end else begin
                vga_in = mkbus(11'd0, 11'd600, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
            end
            tick;
            if (i >= 1) begin
                n_tests++;
                if (vga_out[11:0] !== expv[i - 1]) begin
                    n_fail++;
                    $display("FAIL score31_x%0d: got %h expected %h", 751 + i, vga_out[11:0], expv[i - 1]);
                end
            end
        end
        vga_in = mkbus(11'd752, 11'd47, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        #1;
        n_tests++;
        if (char_addr !== 11'h337) begin
            n_fail++;
            $display("FAIL addr31_tens: got %h expected 337", char_addr);
        end
        vga_in = mkbus(11'd760, 11'd47, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        #1;
        n_tests++;
        if (char_addr !== 11'h317) begin
            n_fail++;
            $display("FAIL addr31_units: got %h expected 317", char_addr);
        end
    endtask

    task automatic test_reset_mid_convert;
        logic [11:0] expv [16];
        vga_in = mkbus(11'd0, 11'd600, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        tick;
        pl1_score = 5'd21;
        pl2_score = 5'd5;
        vga_in = mkbus(11'd0, 11'd600, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        tick;
        repeat (3) tick;
        rst = 1'b1;
        vga_in = mkbus(11'd264, 11'd45, 1'b1, 1'b1, 1'b0, 1'b0, 12'hABC);
        tick;
        n_tests++;
        if (vga_out !== 38'd0) begin
            n_fail++;
            $display("FAIL midconv_rst_out: got %h expected 0", vga_out);
        end
        rst = 1'b0;
        repeat (8) tick;
        // Displayed digits are 0/0: player 2 field shows a single '0'
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                vga_in = mkbus(11'(752 + i), 11'd41, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0C3);
                expv[i] = exp_rgb(0, 0, i, 1, 12'h0C3);
            end else begin
                vga_in = mkbus(11'd0, 11'd600, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
            end
            tick;
            if (i >= 1) begin
                n_tests++;
                if (vga_out[11:0] !== expv[i - 1]) begin
                    n_fail++;
                    $display("FAIL postrst_zero_x%0d: got %h expected %h", 751 + i, vga_out[11:0], expv[i - 1]);
                end
            end
        end
        // First vblank after reset converts afresh within 7 clocks
        vga_in = mkbus(11'd256, 11'd40, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        tick;
        repeat (6) tick;
        #1;
        n_tests++;
        if (char_addr !== 11'h320) begin
            n_fail++;
            $display("FAIL postrst_pl1_tens: got %h expected 320", char_addr);
        end
        vga_in = mkbus(11'd760, 11'd40, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        #1;
        n_tests++;
        if (char_addr !== 11'h350) begin
            n_fail++;
            $display("FAIL postrst_pl2_units: got %h expected 350", char_addr);
        end
        vga_in = mkbus(11'd0, 11'd600, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        tick;
    endtask

    task automatic test_back_to_back;
        // Display holds 21/5; a second vblank start mid-conversion restarts it
        pl1_score = 5'd4;
        pl2_score = 5'd8;
        vga_in = mkbus(11'd0, 11'd600, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        tick;
        tick;
        tick;
        vga_in = mkbus(11'd0, 11'd600, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        tick;
        pl1_score = 5'd17;
        pl2_score = 5'd29;
        vga_in = mkbus(11'd256, 11'd40, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        tick;
        pl1_score = 5'd0;
        pl2_score = 5'd0;
        repeat (5) tick;
        #1;
        n_tests++;
        if (char_addr !== 11'h320) begin
            n_fail++;
            $display("FAIL restart_hold_old: got %h expected 320", char_addr);
        end
        tick;
        n_tests++;
        if (char_addr !== 11'h310) begin
            n_fail++;
            $display("FAIL restart_pl1_tens: got %h expected 310", char_addr);
        end
        vga_in = mkbus(11'd264, 11'd40, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        #1;
        n_tests++;
        if (char_addr !== 11'h370) begin
            n_fail++;
            $display("FAIL restart_pl1_units: got %h expected 370", char_addr);
        end
        vga_in = mkbus(11'd752, 11'd40, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        #1;
        n_tests++;
        if (char_addr !== 11'h320) begin
            n_fail++;
            $display("FAIL restart_pl2_tens: got %h expected 320", char_addr);
        end
        vga_in = mkbus(11'd760, 11'd40, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        #1;
        n_tests++;
        if (char_addr !== 11'h390) begin
            n_fail++;
            $display("FAIL restart_pl2_units: got %h expected 390", char_addr);
        end
    endtask

    initial begin
        rst       = 1'b1;
        vga_in    = '0;
        pl1_score = '0;
        pl2_score = '0;
        test_reset;
        test_latency;
        test_digits;
        test_blank;
        test_midframe;
        test_extremes;
        test_reset_mid_convert;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
